// File: rtl/game_gfx_pkg.sv
// game_gfx_pkg: shared types, colours and helpers for game_graphics_pipe.
// Coordinates are signed so boxes clipping window edges never wrap.
package game_gfx_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam logic [11:0] DEF_PLAYER_COLOR   = 12'hF00;
  localparam logic [11:0] DEF_FLASH_COLOR    = 12'hFFF;
  localparam logic [11:0] DEF_OBSTACLE_COLOR = 12'h0F0;
  localparam logic [11:0] DEF_BKG_COLOR      = 12'h00F;
  localparam logic [11:0] DEF_BORDER_COLOR   = 12'hFF0;

  // clog2(max(WIN_W, WIN_H, 2048)) + 2 for windows up to 2048 pixels
  localparam int COORD_W = 13;

  typedef logic signed [COORD_W-1:0] coord_t;

  // Inclusive square test around (cx, cy) with half-size hs
  function automatic logic in_box(
    input coord_t lx,
    input coord_t ly,
    input coord_t cx,
    input coord_t cy,
    input coord_t hs
  );
    return (lx >= cx - hs) && (lx <= cx + hs) &&
           (ly >= cy - hs) && (ly <= cy + hs);
  endfunction

endpackage

// File: rtl/game_graphics_pipe_delay.sv
// gfx_delay_line: DEPTH-cycle register delay, DEPTH = 0 is a wire.
// Used to align stage-0 flags with the obstacle map read latency.
module gfx_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n;
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stg [DEPTH];

    // Shift register, cleared to "invalid" on reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/game_graphics_pipe.sv
// game_graphics_pipe: pipelined multi-sprite playfield compositor.
// Optional border drawing enabled by defining GAME_GFX_BORDER_EN.
module game_graphics_pipe
  import game_gfx_pkg::*;
#(
  parameter int          WIN_X          = 400,
  parameter int          WIN_Y          = 0,
  parameter int          WIN_W          = 400,
  parameter int          WIN_H          = 600,
  parameter int          PLAYER_SIZE    = 20,
  parameter int          NUM_PLAYERS    = 2,
  parameter int          OBST_LAT       = 1,
  parameter int          FLASH_FRAMES   = 8,
  parameter logic [11:0] PLAYER_COLOR   = DEF_PLAYER_COLOR,
  parameter logic [11:0] FLASH_COLOR    = DEF_FLASH_COLOR,
  parameter logic [11:0] OBSTACLE_COLOR = DEF_OBSTACLE_COLOR,
  parameter logic [11:0] BKG_COLOR      = DEF_BKG_COLOR,
  parameter logic [11:0] BORDER_COLOR   = DEF_BORDER_COLOR
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_disp_enbl,
  input  logic [10:0] i_h_coord,
  input  logic [9:0]  i_v_coord,
  input  logic i_frame_start,
  input  logic [NUM_PLAYERS*$clog2(WIN_W)-1:0] i_player_x,
  input  logic [NUM_PLAYERS*$clog2(WIN_H)-1:0] i_player_y,
  input  logic [NUM_PLAYERS-1:0] i_player_en,
  input  logic i_hit,
  output logic [$clog2(WIN_W)-1:0] o_screen_x,
  output logic [$clog2(WIN_H)-1:0] o_screen_y,
  input  logic i_is_obstacle,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue
);

  localparam int XW = $clog2(WIN_W);
  localparam int YW = $clog2(WIN_H);
  localparam int NP = NUM_PLAYERS;
`ifdef GAME_GFX_BORDER_EN
  localparam int FW = NP + 3;
`else
  localparam int FW = NP + 2;
`endif

  localparam coord_t HS   = coord_t'(PLAYER_SIZE / 2);
  localparam coord_t W_S  = coord_t'(WIN_W);
  localparam coord_t H_S  = coord_t'(WIN_H);

  coord_t lx;
  coord_t ly;
  logic   in_win;

  assign lx = coord_t'(i_h_coord) - coord_t'(WIN_X);
  assign ly = coord_t'(i_v_coord) - coord_t'(WIN_Y);

  assign in_win = (lx >= 0) && (lx < W_S) &&
                  (ly >= 0) && (ly < H_S);

  assign o_screen_x = in_win ? lx[XW-1:0] : '0;
  assign o_screen_y = in_win ? ly[YW-1:0] : '0;

  logic [NP*XW-1:0] px_sh;
  logic [NP*YW-1:0] py_sh;
  logic [NP-1:0]    en_sh;

  // Frame-latched sprite state so a frame never tears
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      px_sh <= '0;
      py_sh <= '0;
      en_sh <= '0;
    end else if (i_frame_start) begin
      px_sh <= i_player_x;
      py_sh <= i_player_y;
      en_sh <= i_player_en;
    end
  end

  logic [3:0] fcnt;

  // Hit flash counter: hit reloads, each frame counts down
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fcnt <= '0;
    end else if (i_hit) begin
      fcnt <= 4'(FLASH_FRAMES);
    end else if (i_frame_start && fcnt != '0) begin
      fcnt <= fcnt - 4'd1;
    end
  end

  logic [NP-1:0] hits;

  for (genvar p = 0; p < NP; p++) begin : g_hit
    coord_t cx;
    coord_t cy;
    assign cx = coord_t'(px_sh[p*XW +: XW]);
    assign cy = coord_t'(py_sh[p*YW +: YW]);
    assign hits[p] = en_sh[p] && in_box(lx, ly, cx, cy, HS);
  end

  logic [FW-1:0] s0_flags;
  logic [FW-1:0] dl_flags;

`ifdef GAME_GFX_BORDER_EN
  logic edge_px;
  assign edge_px = in_win && (lx == 0 || lx == W_S - 1 ||
                              ly == 0 || ly == H_S - 1);
  assign s0_flags = {edge_px, i_disp_enbl, in_win, hits};
`else
  logic unused_cfg;
  assign unused_cfg = ^BORDER_COLOR;
  assign s0_flags = {i_disp_enbl, in_win, hits};
`endif

  gfx_delay_line #(
    .WIDTH(FW),
    .DEPTH(OBST_LAT)
  ) u_flags (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .d    (s0_flags),
    .q    (dl_flags)
  );

  rgb_t spr_col;
  rgb_t pix;
  rgb_t rgb_q;

  assign spr_col = (fcnt != '0 && fcnt[0]) ? rgb_t'(FLASH_COLOR)
                                           : rgb_t'(PLAYER_COLOR);

  // Composite the aligned flags with the obstacle flag, highest first
  always_comb begin
    pix = '0;
    if (!dl_flags[NP+1]) begin
      pix = '0;
    end else if (!dl_flags[NP]) begin
      pix = '0;
`ifdef GAME_GFX_BORDER_EN
    end else if (dl_flags[NP+2]) begin
      pix = rgb_t'(BORDER_COLOR);
`endif
    end else if (|dl_flags[NP-1:0]) begin
      pix = spr_col;
    end else if (i_is_obstacle) begin
      pix = rgb_t'(OBSTACLE_COLOR);
    end else begin
      pix = rgb_t'(BKG_COLOR);
    end
  end

  // Registered RGB towards the pins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rgb_q <= '0;
    else          rgb_q <= pix;
  end

  assign o_red   = rgb_q.r;
  assign o_green = rgb_q.g;
  assign o_blue  = rgb_q.b;

endmodule
